// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter driving the registered 32-to-1 mux select code.
// Optional forced release after TIMEOUT_CYCLES of ownership: define BUS_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner, searching for the next requester after last_idx
// SETUP | grant issued, waiting one cycle for the mux register to load
// OWN   | bus carries the granted source, bus_valid high
module bus_arbiter #(
  parameter int NUM_REQ        = 25,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [4:0]         select,
  output logic               bus_valid,
  output logic               busy,
  output logic               timeout_err
);

  if (NUM_REQ < 1 || NUM_REQ > 25 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
    $error("bus_arbiter: NUM_REQ must be 1..25 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, OWN} state_t;

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_t             state;
  logic [4:0]         idx;
  logic [4:0]         last_idx;
  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [4:0]         win;
  logic [5:0]         sum;

  function automatic logic [4:0] sel_code(input logic [4:0] k);
    case (k)
      5'd0:    return 5'd1;
      5'd1:    return 5'd3;
      5'd2:    return 5'd2;
      default: return k + 5'd1;
    endcase
  endfunction

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]   own_cnt;
  logic [NUM_REQ-1:0] blocked;
  logic               terr_q;

  // a source released by timeout stays masked until it drops its request
  assign eligible    = req & ~blocked;
  assign timeout_err = terr_q;
`else
  assign eligible    = req;
  assign timeout_err = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, last_idx} + 6'(i) + 6'd1;
      if (sum >= 6'(NUM_REQ)) sum = sum - 6'(NUM_REQ);
      if (!found && eligible[sum[4:0]]) begin
        found = 1'b1;
        win   = sum[4:0];
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      idx       <= '0;
      last_idx  <= 5'(NUM_REQ - 1);
      gnt       <= '0;
      select    <= '0;
      bus_valid <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      own_cnt   <= '0;
      blocked   <= '0;
      terr_q    <= 1'b0;
`endif
    end else begin
`ifdef BUS_ARB_TIMEOUT_EN
      terr_q  <= 1'b0;
      blocked <= blocked & req;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            idx    <= win;
            gnt    <= ONE << win;
            select <= sel_code(win);
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (req[idx]) begin
            bus_valid <= 1'b1;
            state     <= OWN;
`ifdef BUS_ARB_TIMEOUT_EN
            own_cnt   <= '0;
`endif
          end else begin
            gnt      <= '0;
            select   <= '0;
            last_idx <= idx;
            state    <= IDLE;
          end
        end
        OWN: begin
          if (!req[idx]) begin
            gnt       <= '0;
            select    <= '0;
            bus_valid <= 1'b0;
            last_idx  <= idx;
            state     <= IDLE;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (own_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            gnt          <= '0;
            select       <= '0;
            bus_valid    <= 1'b0;
            last_idx     <= idx;
            blocked[idx] <= 1'b1;
            terr_q       <= 1'b1;
            state        <= IDLE;
          end else begin
            own_cnt <= own_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random request
// traffic compared against a tenure-level reference model.
module tb_bus_arbiter;
  localparam int NUM = 25;
  localparam int TO  = 4;

  logic           clk = 1'b0;
  logic           clear_n = 1'b0;
  logic [NUM-1:0] req = '0;
  logic [NUM-1:0] gnt;
  logic [4:0]     select;
  logic           bus_valid;
  logic           busy;
  logic           timeout_err;

  bus_arbiter #(.NUM_REQ(NUM), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .clear_n(clear_n), .req(req), .gnt(gnt), .select(select),
    .bus_valid(bus_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: current owner (-1 none), cycles the owner has had valid data
  int             m_owner;
  int             m_age;
  int             m_ptr;
  logic [NUM-1:0] m_blocked;
  logic           m_terr;

  function automatic int code_of(input int k);
    if (k == 0) return 1;
    if (k == 1) return 3;
    if (k == 2) return 2;
    return k + 1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_ptr = NUM - 1; m_blocked = '0; m_terr = 1'b0;
  endtask

  task automatic model_step(input logic [NUM-1:0] r);
    int nxt;
    m_terr = 1'b0;
    m_blocked = m_blocked & r;
    if (m_owner < 0) begin
      for (int i = 1; i <= NUM; i++) begin
        nxt = (m_ptr + i) % NUM;
        if (r[nxt] && !m_blocked[nxt]) begin
          m_owner = nxt; m_age = 0;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr = m_owner; m_owner = -1;
    end else if (m_age == 0) begin
      m_age = 1;
`ifdef BUS_ARB_TIMEOUT_EN
    end else if (m_age == TO) begin
      m_ptr = m_owner; m_blocked[m_owner] = 1'b1; m_terr = 1'b1; m_owner = -1;
`endif
    end else begin
      m_age++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NUM-1:0] eg;
    eg = (m_owner >= 0) ? (NUM'(1) << m_owner) : '0;
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".select"}, 32'(select), (m_owner >= 0) ? 32'(code_of(m_owner)) : 32'd0);
    chk({tag, ".bus_valid"}, 32'(bus_valid), 32'(m_owner >= 0 && m_age >= 1));
    chk({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(m_terr));
  endtask

  // called just after a falling edge; leaves the bench just after the next one
  task automatic step(input logic [NUM-1:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic apply_reset(input logic [NUM-1:0] r);
    clear_n = 1'b0;
    req = r;
    #1;
    model_reset();
    check_all("rst_assert");
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_all("rst_hold");
    end
    #2 clear_n = 1'b1;
    #1 check_all("rst_release");
  endtask

  initial begin
    logic [NUM-1:0] r;
    int pend;
    int bv_cnt;
    int te_cnt;
    logic prev_busy;
    logic [4:0] order[$];

    model_reset();
    @(negedge clk);

    // reset with every source requesting, then first grant goes to index 0
    apply_reset('1);
    step('1, "first_grant");
    chk("first_sel", 32'(select), 32'd1);
    chk("first_gnt", 32'(gnt), 32'h1);
    step('1, "first_own");
    step('0, "first_rel");
    step('0, "first_idle");

    // single source 1
    apply_reset('0);
    r = '0; r[1] = 1'b1;
    step(r, "single_grant");
    chk("single_gnt", 32'(gnt), 32'h2);
    chk("single_sel", 32'(select), 32'd3);
    step(r, "single_setup");
    chk("single_valid", 32'(bus_valid), 32'd1);
    repeat (3) step(r, "single_own");
    step('0, "single_rel");
    chk("single_clear", 32'({gnt, select, bus_valid}), 32'd0);
    step('0, "single_idle");

    // contention between 0, 2 and 24, each dropping briefly after two valid cycles
    apply_reset('0);
    r = '0; r[0] = 1'b1; r[2] = 1'b1; r[24] = 1'b1;
    pend = -1;
    prev_busy = 1'b0;
    order.delete();
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      if (pend >= 0) begin r[pend] = 1'b1; pend = -1; end
      if (m_owner >= 0 && m_age == 2) begin r[m_owner] = 1'b0; pend = m_owner; end
      step(r, "contend");
      if (busy && !prev_busy) order.push_back(select);
      prev_busy = busy;
    end
    chk("contend_count", 32'(order.size()), 32'd4);
    if (order.size() == 4) begin
      chk("contend_sel0", 32'(order[0]), 32'd1);
      chk("contend_sel1", 32'(order[1]), 32'd2);
      chk("contend_sel2", 32'(order[2]), 32'd25);
      chk("contend_sel3", 32'(order[3]), 32'd1);
    end
    step('0, "contend_end");
    step('0, "contend_end");

    // abort: one-cycle request from 7, then 3 and 9 compete -> 9 wins
    apply_reset('0);
    r = '0; r[7] = 1'b1;
    step(r, "abort_grant");
    chk("abort_sel", 32'(select), 32'd8);
    step('0, "abort_drop");
    chk("abort_valid", 32'(bus_valid), 32'd0);
    r = '0; r[3] = 1'b1; r[9] = 1'b1;
    step(r, "abort_next");
    chk("abort_next_sel", 32'(select), 32'd10);
    step('0, "abort_end");
    step('0, "abort_end");

    // source 3 holds its request indefinitely
    apply_reset('0);
    r = '0; r[3] = 1'b1;
    bv_cnt = 0; te_cnt = 0;
    repeat (14) begin
      step(r, "hold3");
      if (bus_valid) bv_cnt++;
      if (timeout_err) te_cnt++;
    end
`ifdef BUS_ARB_TIMEOUT_EN
    chk("hold3_valid_cycles", 32'(bv_cnt), 32'(TO));
    chk("hold3_terr_pulses", 32'(te_cnt), 32'd1);
`else
    chk("hold3_valid_cycles", 32'(bv_cnt), 32'd13);
    chk("hold3_terr_pulses", 32'(te_cnt), 32'd0);
`endif
    step('0, "hold3_drop");
    step('0, "hold3_drop");
    step(r, "hold3_regrant");
    chk("hold3_regrant_sel", 32'(select), 32'd4);
    step(r, "hold3_regrant");
    step('0, "hold3_end");
    step('0, "hold3_end");

    // asynchronous reset in the middle of source 5's tenure
    apply_reset('0);
    r = '0; r[5] = 1'b1;
    repeat (3) step(r, "own5");
    chk("own5_valid", 32'(bus_valid), 32'd1);
    #2 clear_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_own_rst");
    chk("mid_own_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    check_all("mid_own_hold");
    #2 clear_n = 1'b1;
    r[0] = 1'b1;
    step(r, "post_rst");
    chk("post_rst_sel", 32'(select), 32'd1);
    step('0, "post_rst_end");
    step('0, "post_rst_end");

    // random traffic against the model
    apply_reset('0);
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NUM; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      step(r, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
